// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB pipeline register with load alignment, write-back select and retire counter
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_valid,
    input  logic             m_reg_write,
    input  logic [1:0]       m_result_src,
    input  logic [2:0]       m_funct3,
    input  logic [XLEN-1:0]  m_alu_result,
    input  logic [XLEN-1:0]  m_read_data,
    input  logic [XLEN-1:0]  m_pc_plus4,
    input  logic [XLEN-1:0]  m_imm_ext,
    input  logic [4:0]       m_rd,
    output logic             we3,
    output logic [XLEN-1:0]  wd3,
    output logic [4:0]       a3,
    output logic             w_valid,
    output logic             w_load_err,
    output logic [CNT_W-1:0] instret
);

    logic            w_reg_write;
    logic [1:0]      w_result_src;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_alu_result;
    logic [XLEN-1:0] w_read_data;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_imm_ext;
    logic [4:0]      w_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_valid      <= 1'b0;
            w_reg_write  <= 1'b0;
            w_result_src <= 2'b00;
            w_funct3     <= 3'b000;
            w_alu_result <= '0;
            w_read_data  <= '0;
            w_pc_plus4   <= '0;
            w_imm_ext    <= '0;
            w_rd         <= 5'd0;
            instret      <= '0;
        end else if (flush) begin
            w_valid <= 1'b0;
        end else if (!stall) begin
            w_valid      <= m_valid;
            w_reg_write  <= m_reg_write;
            w_result_src <= m_result_src;
            w_funct3     <= m_funct3;
            w_alu_result <= m_alu_result;
            w_read_data  <= m_read_data;
            w_pc_plus4   <= m_pc_plus4;
            w_imm_ext    <= m_imm_ext;
            w_rd         <= m_rd;
            if (m_valid) instret <= instret + CNT_W'(1);
        end
    end

    logic [1:0]      off;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            size_bad;
    logic [XLEN-1:0] load_val;

    assign off     = w_alu_result[1:0];
    assign ld_byte = w_read_data[{off, 3'b000} +: 8];
    assign ld_half = w_read_data[{off[1], 4'b0000} +: 16];

    always_comb begin
        size_bad = 1'b0;
        load_val = '0;
        case (w_funct3)
            3'b000: load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100: load_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001: begin
                size_bad = off[0];
                load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            end
            3'b101: begin
                size_bad = off[0];
                load_val = {{(XLEN-16){1'b0}}, ld_half};
            end
            3'b010: begin
                size_bad = (off != 2'b00);
                load_val = w_read_data;
            end
            default: size_bad = 1'b1;
        endcase
    end

    assign w_load_err = w_valid && (w_result_src == 2'b01) && size_bad;

    // Faulting loads deliver 0 so a suppressed write never leaks partial data.
    always_comb begin
        wd3 = '0;
        case (w_result_src)
            2'b00: wd3 = w_alu_result;
            2'b01: wd3 = w_load_err ? '0 : load_val;
            2'b10: wd3 = w_pc_plus4;
            2'b11: wd3 = w_imm_ext;
            default: wd3 = '0;
        endcase
    end

    assign a3  = w_rd;
    assign we3 = w_valid && w_reg_write && (w_rd != 5'd0) && !w_load_err;

endmodule
